// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbitrated config register bank shared by NUM_REQ requesters.
// Optional feature macro REG_WRITE_LOCK_EN: bit 0 of register NUM_REGS-1 locks out writes from requesters 1..NUM_REQ-1.
module reg_bank_arbiter #(
    parameter  int NUM_REQ  = 2,
    parameter  int NUM_REGS = 8,
    parameter  int DATA_W   = 8,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       ena,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_gnt,
    output logic [NUM_REQ-1:0]         rsp_vld,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [NUM_REGS*DATA_W-1:0] config_regs,
    output logic [7:0]                 conflict_cnt,
    output logic                       lock_err
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [DATA_W-1:0] bank [NUM_REGS];
    logic [PTR_W-1:0]  rr_ptr;

    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              addr_ok;
    logic [DATA_W-1:0] rd_data;
    logic              wr_blocked;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = rr_ptr;
        if (rstb && ena) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
                if (!gnt_any && req_vld[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_gnt = '0;
        if (gnt_any) req_gnt[gnt_idx] = 1'b1;
    end

    assign sel_addr  = addr_a[gnt_idx];
    assign sel_wdata = wdata_a[gnt_idx];
    assign sel_we    = req_we[gnt_idx];
    assign addr_ok   = {1'b0, sel_addr} < (ADDR_W + 1)'(NUM_REGS);
    assign rd_data   = addr_ok ? bank[sel_addr] : '0;

`ifdef REG_WRITE_LOCK_EN
    assign wr_blocked = bank[NUM_REGS-1][0] && (gnt_idx != '0);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) lock_err <= 1'b0;
        else       lock_err <= gnt_any && sel_we && wr_blocked;
    end
`else
    assign wr_blocked = 1'b0;
    assign lock_err   = 1'b0;
`endif

    // NOTE: the bank is a small flop array whose reset value is architecturally visible on config_regs, so every entry is reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int r = 0; r < NUM_REGS; r++) bank[r] <= '0;
            rr_ptr       <= PTR_LAST;
            rsp_vld      <= '0;
            rsp_rdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            rsp_vld <= '0;
            if (ena && ($countones(req_vld) > 1) && (conflict_cnt != 8'hFF))
                conflict_cnt <= conflict_cnt + 8'd1;
            if (gnt_any) begin
                rr_ptr <= gnt_idx;
                if (sel_we) begin
                    if (addr_ok && !wr_blocked) bank[sel_addr] <= sel_wdata;
                end else begin
                    rsp_vld   <= req_gnt;
                    rsp_rdata <= rd_data;
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) config_regs[r*DATA_W +: DATA_W] = bank[r];
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Testbench for reg_bank_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_bank_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);
`ifdef REG_WRITE_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rstb = 1'b0;
    logic                       ena = 1'b0;
    logic [NUM_REQ-1:0]         req_vld = '0;
    logic [NUM_REQ-1:0]         req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata = '0;
    logic [NUM_REQ-1:0]         req_gnt;
    logic [NUM_REQ-1:0]         rsp_vld;
    logic [DATA_W-1:0]          rsp_rdata;
    logic [NUM_REGS*DATA_W-1:0] config_regs;
    logic [7:0]                 conflict_cnt;
    logic                       lock_err;

    reg_bank_arbiter #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .req_vld(req_vld), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt), .rsp_vld(rsp_vld),
        .rsp_rdata(rsp_rdata), .config_regs(config_regs), .conflict_cnt(conflict_cnt),
        .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int                 m_bank [NUM_REGS];
    int                 m_ptr;
    int                 m_cnt;
    logic [NUM_REQ-1:0] m_rsp;
    int                 m_rdata;
    bit                 m_lerr;
    logic [NUM_REQ-1:0] last_gnt;

    function automatic void model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_bank[r] = 0;
        m_ptr = NUM_REQ - 1; m_cnt = 0; m_rsp = '0; m_rdata = 0; m_lerr = 1'b0;
    endfunction

    function automatic int model_pick();
        if (!ena || !rstb) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i = (m_ptr + k) % NUM_REQ;
            if (req_vld[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_edge(int gi);
        int a, d;
        m_rsp = '0; m_lerr = 1'b0;
        if (ena && $countones(req_vld) >= 2 && m_cnt < 255) m_cnt++;
        if (gi >= 0) begin
            m_ptr = gi;
            a = int'(req_addr[gi*ADDR_W +: ADDR_W]);
            d = int'(req_wdata[gi*DATA_W +: DATA_W]);
            if (req_we[gi]) begin
                if (LOCK_ON && m_bank[NUM_REGS-1] % 2 == 1 && gi != 0) m_lerr = 1'b1;
                else if (a < NUM_REGS) m_bank[a] = d;
            end else begin
                m_rsp[gi] = 1'b1;
                m_rdata = (a < NUM_REGS) ? m_bank[a] : 0;
            end
        end
    endfunction

    function automatic logic [NUM_REGS*DATA_W-1:0] model_regs();
        logic [NUM_REGS*DATA_W-1:0] v;
        for (int r = 0; r < NUM_REGS; r++) v[r*DATA_W +: DATA_W] = DATA_W'(m_bank[r]);
        return v;
    endfunction

    // One clock: checks grant before the edge, then every registered output after it.
    task automatic tick();
        int gi;
        logic [NUM_REQ-1:0] eg;
        @(negedge clk);
        gi = model_pick();
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        last_gnt = req_gnt;
        checks++;
        if (req_gnt !== eg) begin errors++; $display("FAIL gnt t=%0t got=%b exp=%b", $time, req_gnt, eg); end
        @(posedge clk);
        model_edge(gi);
        #1;
        checks++;
        if (rsp_vld !== m_rsp) begin errors++; $display("FAIL rsp_vld t=%0t got=%b exp=%b", $time, rsp_vld, m_rsp); end
        checks++;
        if (rsp_rdata !== DATA_W'(m_rdata)) begin errors++; $display("FAIL rsp_rdata t=%0t got=%h exp=%h", $time, rsp_rdata, DATA_W'(m_rdata)); end
        checks++;
        if (config_regs !== model_regs()) begin errors++; $display("FAIL config_regs t=%0t got=%h exp=%h", $time, config_regs, model_regs()); end
        checks++;
        if (conflict_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL conflict_cnt t=%0t got=%0d exp=%0d", $time, conflict_cnt, m_cnt); end
        checks++;
        if (lock_err !== m_lerr) begin errors++; $display("FAIL lock_err t=%0t got=%b exp=%b", $time, lock_err, m_lerr); end
    endtask

    task automatic set_req(int i, bit vld, bit we, int addr, int wdata);
        req_vld[i] = vld;
        req_we[i]  = we;
        req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
        req_wdata[i*DATA_W +: DATA_W] = DATA_W'(wdata);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rstb = 1'b0; ena = 1'b1;
        req_vld = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        model_reset();
        @(posedge clk); #1;
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rstb = 1'b0; ena = 1'b1; req_vld = '1;
        model_reset();
        @(negedge clk);
        checks++;
        if (req_gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", req_gnt); end
        checks++;
        if (rsp_vld !== '0 || config_regs !== '0 || conflict_cnt !== 8'd0 || lock_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rsp_vld=%b regs=%h cnt=%0d lock_err=%b exp all zero", rsp_vld, config_regs, conflict_cnt, lock_err);
        end
        @(posedge clk); #1;
        req_vld = '0;
        rstb = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        set_req(0, 1, 1, 3, 8'hA5);
        tick();
        checks++;
        if (config_regs[31:24] !== 8'hA5) begin errors++; $display("FAIL wr_visible got=%h exp=a5", config_regs[31:24]); end
        set_req(0, 1, 0, 3, 0);
        tick();
        checks++;
        if (rsp_vld !== 2'b01 || rsp_rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_after_wr got vld=%b data=%h exp vld=01 data=a5", rsp_vld, rsp_rdata);
        end
        set_req(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_round_robin();
        int done [NUM_REQ];
        apply_reset();
        done[0] = 0; done[1] = 0;
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 1, 5, 8'h3C);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (last_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_order cycle=%0d got=%b exp=%b", k, last_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            for (int i = 0; i < NUM_REQ; i++) if (last_gnt[i]) done[i]++;
        end
        checks++;
        if (conflict_cnt !== 8'd4) begin errors++; $display("FAIL rr_conflict got=%0d exp=4", conflict_cnt); end
        checks++;
        if (done[0] != 2 || done[1] != 2) begin errors++; $display("FAIL rr_done got=%0d,%0d exp=2,2", done[0], done[1]); end
    endtask

    task automatic test_saturation();
        logic [NUM_REQ-1:0] prev;
        prev = last_gnt;
        for (int k = 0; k < 300; k++) begin
            set_req(0, 1, 0, $urandom_range(0, 7), 0);
            set_req(1, 1, $urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 255));
            tick();
            checks++;
            if (last_gnt === prev || last_gnt === '0) begin
                errors++; $display("FAIL sat_alternate cycle=%0d got=%b prev=%b", k, last_gnt, prev);
            end
            prev = last_gnt;
        end
        checks++;
        if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", conflict_cnt); end
        req_vld = '0;
        tick();
    endtask

    task automatic test_enable();
        logic [NUM_REGS*DATA_W-1:0] snap;
        apply_reset();
        set_req(0, 1, 1, 4, 8'h11);
        set_req(1, 1, 1, 6, 8'h22);
        ena = 1'b0;
        snap = config_regs;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (config_regs !== snap || conflict_cnt !== 8'd0) begin
            errors++; $display("FAIL ena_hold regs=%h cnt=%0d exp regs=%h cnt=0", config_regs, conflict_cnt, snap);
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (req_gnt !== 2'b01) begin errors++; $display("FAIL ena_first got=%b exp=01", req_gnt); end
        @(posedge clk); #1;
        ena = 1'b0;
        apply_reset();
    endtask

    task automatic test_lock();
        apply_reset();
`ifdef REG_WRITE_LOCK_EN
        set_req(0, 1, 1, 7, 8'h01); tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 1, 2, 8'h55); tick();
        checks++;
        if (lock_err !== 1'b1 || config_regs[23:16] !== 8'h00) begin
            errors++; $display("FAIL lock_block lock_err=%b reg2=%h exp 1,00", lock_err, config_regs[23:16]);
        end
        set_req(1, 0, 0, 0, 0); tick();
        set_req(0, 1, 1, 7, 8'h00); tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 1, 2, 8'h55); tick();
        checks++;
        if (lock_err !== 1'b0 || config_regs[23:16] !== 8'h55) begin
            errors++; $display("FAIL lock_release lock_err=%b reg2=%h exp 0,55", lock_err, config_regs[23:16]);
        end
`else
        set_req(1, 1, 1, 7, 8'h01); tick();
        set_req(1, 1, 1, 2, 8'h55); tick();
        checks++;
        if (lock_err !== 1'b0 || config_regs[23:16] !== 8'h55 || config_regs[63:56] !== 8'h01) begin
            errors++; $display("FAIL nolock lock_err=%b reg2=%h reg7=%h exp 0,55,01", lock_err, config_regs[23:16], config_regs[63:56]);
        end
`endif
        req_vld = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        set_req(0, 1, 0, 3, 0);
        @(negedge clk);
        checks++;
        if (req_gnt !== 2'b01) begin errors++; $display("FAIL midrst_gnt got=%b exp=01", req_gnt); end
        #1;
        rstb = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (rsp_vld !== '0) begin errors++; $display("FAIL midrst_rsp got=%b exp=00", rsp_vld); end
        req_vld = '0;
        rstb = 1'b1;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            ena = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, NUM_REGS - 1),
                        (i == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(0, 255));
            tick();
        end
        req_vld = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_saturation();
        test_enable();
        test_lock();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
